// File: rtl/spi_slave_core_if.sv
// Holding-register handshake between spi_slave_core and its host logic.
// The master modport is the host side; the slave modport is the core side.
interface spi_slave_core_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] tx_data;
  logic              tx_load;
  logic              tx_ready;
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic              rx_ack;
  logic              rx_overrun;

  modport master (
    output tx_data, tx_load, rx_ack,
    input  tx_ready, rx_data, rx_valid, rx_overrun
  );

  modport slave (
    input  tx_data, tx_load, rx_ack,
    output tx_ready, rx_data, rx_valid, rx_overrun
  );
endinterface

// File: rtl/spi_slave_core.sv
// SPI target shift engine. SCLK, SS_n and MOSI are oversampled into the clk
// domain; all four CPOL/CPHA modes and MSB/LSB-first order are supported.
// Optional feature: define SPI_SLAVE_RX_OVERRUN_EN to keep an unacknowledged
// word and flag a sticky overrun instead of overwriting rx_data.
//
// state  | meaning
// IDLE   | not selected, MISO released
// ACTIVE | selected, shifting bits on normalised SCLK edges
module spi_slave_core #(
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sclk,
  input  logic             ss_n,
  input  logic             mosi,
  output logic             miso,
  output logic             miso_oe,
  input  logic             cpol,
  input  logic             cpha,
  input  logic             lsbfe,
  spi_slave_core_if.slave  host
);

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} state_t;

  state_t state_q, state_d;

  logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
  logic [SYNC_STAGES-1:0] ss_sync_q, ss_sync_d;
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  logic                   ck_q, ck_d;
  logic                   ss_prev_q, ss_prev_d;

  logic [DATA_W-1:0] tx_shift_q, tx_shift_d;
  logic [DATA_W-1:0] rx_shift_q, rx_shift_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic              miso_q, miso_d;
  logic              miso_oe_q, miso_oe_d;
  logic [DATA_W-1:0] hold_q, hold_d;
  logic              tx_ready_q, tx_ready_d;
  logic [DATA_W-1:0] rx_data_q, rx_data_d;
  logic              rx_valid_q, rx_valid_d;
`ifdef SPI_SLAVE_RX_OVERRUN_EN
  logic              rx_overrun_q, rx_overrun_d;
`endif

  logic sclk_s, ss_s, mosi_s;
  logic ck, lead_edge, trail_edge, sample_edge, shift_edge;
  logic ss_fall, ss_rise;
  logic select_evt, deselect_evt, run;
  logic [DATA_W-1:0] load_word;
  logic [DATA_W-1:0] rx_word;
  logic              word_done;
  logic              xfer;

  // First bit to go out for the configured order.
  function automatic logic head_bit(input logic [DATA_W-1:0] w, input logic lsb);
    return lsb ? w[0] : w[DATA_W-1];
  endfunction

  // Advance the tx word by one bit for the configured order.
  function automatic logic [DATA_W-1:0] shift_out(input logic [DATA_W-1:0] w,
                                                  input logic lsb);
    return lsb ? (w >> 1) : (w << 1);
  endfunction

  assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
  assign ss_s   = ss_sync_q[SYNC_STAGES-1];
  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

  assign ck          = sclk_s ^ cpol;
  assign lead_edge   = ck & ~ck_q;
  assign trail_edge  = ~ck & ck_q;
  assign sample_edge = cpha ? trail_edge : lead_edge;
  assign shift_edge  = cpha ? lead_edge : trail_edge;
  assign ss_fall     = ss_prev_q & ~ss_s;
  assign ss_rise     = ~ss_prev_q & ss_s;

  assign select_evt   = (state_q == IDLE) && ss_fall;
  assign deselect_evt = (state_q == ACTIVE) && ss_rise;
  assign run          = (state_q == ACTIVE) && !ss_rise;

  // An empty holding register sends zeros.
  assign load_word = tx_ready_q ? '0 : hold_q;

  // Synchroniser shift chains and edge-detect history.
  always_comb begin
    sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], sclk};
    ss_sync_d   = {ss_sync_q[SYNC_STAGES-2:0], ss_n};
    mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], mosi};
    ck_d        = ck;
    ss_prev_d   = ss_s;
  end

  // Synchroniser flops; sclk resets to its idle level so no edge is seen.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sclk_sync_q <= {SYNC_STAGES{cpol}};
      ss_sync_q   <= '1;
      mosi_sync_q <= '0;
      ck_q        <= 1'b0;
      ss_prev_q   <= 1'b1;
    end else begin
      sclk_sync_q <= sclk_sync_d;
      ss_sync_q   <= ss_sync_d;
      mosi_sync_q <= mosi_sync_d;
      ck_q        <= ck_d;
      ss_prev_q   <= ss_prev_d;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // FSM next state: select and deselect follow the synced ss_n edges.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (ss_fall) state_d = ACTIVE;
      ACTIVE:  if (ss_rise) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs and datapath next values.
  always_comb begin
    tx_shift_d = tx_shift_q;
    rx_shift_d = rx_shift_q;
    bit_cnt_d  = bit_cnt_q;
    miso_d     = miso_q;
    miso_oe_d  = miso_oe_q;
    hold_d     = hold_q;
    tx_ready_d = tx_ready_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = rx_valid_q & ~host.rx_ack;
`ifdef SPI_SLAVE_RX_OVERRUN_EN
    rx_overrun_d = rx_overrun_q;
`endif
    rx_word   = lsbfe ? {mosi_s, rx_shift_q[DATA_W-1:1]}
                      : {rx_shift_q[DATA_W-2:0], mosi_s};
    word_done = 1'b0;
    xfer      = 1'b0;

    if (select_evt) begin
      xfer       = 1'b1;
      bit_cnt_d  = '0;
      rx_shift_d = '0;
      miso_oe_d  = 1'b1;
      // cpha=0 drives the first bit right away; cpha=1 waits for the leading edge.
      if (!cpha) begin
        miso_d     = head_bit(load_word, lsbfe);
        tx_shift_d = shift_out(load_word, lsbfe);
      end else begin
        miso_d     = 1'b0;
        tx_shift_d = load_word;
      end
    end else if (deselect_evt) begin
      miso_oe_d  = 1'b0;
      miso_d     = 1'b0;
      bit_cnt_d  = '0;
      rx_shift_d = '0;
      tx_shift_d = '0;
    end else if (run) begin
      if (shift_edge) begin
        miso_d     = head_bit(tx_shift_q, lsbfe);
        tx_shift_d = shift_out(tx_shift_q, lsbfe);
      end
      if (sample_edge) begin
        if (bit_cnt_q == LAST_BIT) begin
          bit_cnt_d  = '0;
          rx_shift_d = '0;
          word_done  = 1'b1;
          xfer       = 1'b1;
          // Reloaded unshifted: the next shift edge presents the new head bit.
          tx_shift_d = load_word;
        end else begin
          bit_cnt_d  = bit_cnt_q + 1'b1;
          rx_shift_d = rx_word;
        end
      end
    end

    if (xfer && !tx_ready_q) tx_ready_d = 1'b1;
    if (host.tx_load && tx_ready_q) begin
      hold_d     = host.tx_data;
      tx_ready_d = 1'b0;
    end

    if (word_done) begin
`ifdef SPI_SLAVE_RX_OVERRUN_EN
      if (rx_valid_q && !host.rx_ack) begin
        rx_overrun_d = 1'b1;
      end else begin
        rx_data_d  = rx_word;
        rx_valid_d = 1'b1;
      end
`else
      rx_data_d  = rx_word;
      rx_valid_d = 1'b1;
`endif
    end

`ifdef SPI_SLAVE_RX_OVERRUN_EN
    if (ss_rise) rx_overrun_d = 1'b0;
`endif
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_shift_q <= '0;
      rx_shift_q <= '0;
      bit_cnt_q  <= '0;
      miso_q     <= 1'b0;
      miso_oe_q  <= 1'b0;
      hold_q     <= '0;
      tx_ready_q <= 1'b1;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
`ifdef SPI_SLAVE_RX_OVERRUN_EN
      rx_overrun_q <= 1'b0;
`endif
    end else begin
      tx_shift_q <= tx_shift_d;
      rx_shift_q <= rx_shift_d;
      bit_cnt_q  <= bit_cnt_d;
      miso_q     <= miso_d;
      miso_oe_q  <= miso_oe_d;
      hold_q     <= hold_d;
      tx_ready_q <= tx_ready_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
`ifdef SPI_SLAVE_RX_OVERRUN_EN
      rx_overrun_q <= rx_overrun_d;
`endif
    end
  end

  assign miso          = miso_q;
  assign miso_oe       = miso_oe_q;
  assign host.tx_ready = tx_ready_q;
  assign host.rx_data  = rx_data_q;
  assign host.rx_valid = rx_valid_q;
`ifdef SPI_SLAVE_RX_OVERRUN_EN
  assign host.rx_overrun = rx_overrun_q;
`else
  assign host.rx_overrun = 1'b0;
`endif

endmodule

// File: tb/tb_spi_slave_core.sv
// Bench for spi_slave_core: a behavioural SPI master drives directed frames,
// expected rx words go into a queue and a monitor pops them as rx_valid shows.
module tb_spi_slave_core;
  localparam int HALF = 80;

  logic clk, reset, sclk, ss_n, mosi, miso, miso_oe, cpol, cpha, lsbfe;
  logic mon_en;
  int checks, errors;
  logic [7:0] exp_q[$];
  logic [7:0] mi;

  spi_slave_core_if #(.DATA_W(8)) bus ();

  spi_slave_core #(.DATA_W(8), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset(reset), .sclk(sclk), .ss_n(ss_n), .mosi(mosi),
    .miso(miso), .miso_oe(miso_oe), .cpol(cpol), .cpha(cpha), .lsbfe(lsbfe),
    .host(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_mode(input logic cp, input logic ch, input logic lf);
    @(negedge clk);
    cpol = cp; cpha = ch; lsbfe = lf; sclk = cp;
    #100;
  endtask

  task automatic load_tx(input logic [7:0] d);
    @(negedge clk);
    bus.tx_data = d;
    bus.tx_load = 1'b1;
    @(negedge clk);
    bus.tx_load = 1'b0;
  endtask

  task automatic select;
    @(negedge clk);
    ss_n = 1'b0;
    #100;
  endtask

  task automatic deselect;
    #HALF;
    ss_n = 1'b1;
    #100;
  endtask

  // One word (or nbits of it), master side; returns the bits seen on miso.
  task automatic xfer(input logic [7:0] mo, input int nbits, output logic [7:0] mr);
    int idx;
    mr = 8'h00;
    @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      idx = lsbfe ? i : 7 - i;
      if (!cpha) begin
        mosi = mo[idx];
        #HALF; sclk = ~cpol; mr[idx] = miso;
        #HALF; sclk = cpol;
      end else begin
        sclk = ~cpol; mosi = mo[idx];
        #HALF; sclk = cpol; mr[idx] = miso;
        #HALF;
      end
    end
  endtask

  task automatic wait_drain;
    int n = 0;
    while ((exp_q.size() != 0 || bus.rx_valid) && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("drain_pending", 16'(exp_q.size()), 16'd0);
  endtask

  // Monitor: compare and acknowledge each presented word.
  initial begin
    logic [7:0] e;
    bus.rx_ack = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.rx_ack) begin
        bus.rx_ack = 1'b0;
      end else if (mon_en && reset && bus.rx_valid) begin
        chk("rx_expected_present", 16'(exp_q.size() != 0), 16'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("rx_data", 16'(bus.rx_data), 16'(e));
        end
        bus.rx_ack = 1'b1;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0; errors = 0; mon_en = 1'b1;
    reset = 1'b0; ss_n = 1'b1; sclk = 1'b0; mosi = 1'b0;
    cpol = 1'b0; cpha = 1'b0; lsbfe = 1'b0;
    bus.tx_data = 8'h00; bus.tx_load = 1'b0;
    #22;
    chk("rst_miso", 16'(miso), 16'd0);
    chk("rst_miso_oe", 16'(miso_oe), 16'd0);
    chk("rst_tx_ready", 16'(bus.tx_ready), 16'd1);
    chk("rst_rx_valid", 16'(bus.rx_valid), 16'd0);
    chk("rst_rx_data", 16'(bus.rx_data), 16'd0);
    chk("rst_overrun", 16'(bus.rx_overrun), 16'd0);
    #30 reset = 1'b1;
    #50;

    // Mode 0, MSB first
    set_mode(1'b0, 1'b0, 1'b0);
    load_tx(8'hA5);
    chk("t1_tx_ready_full", 16'(bus.tx_ready), 16'd0);
    select;
    chk("t1_miso_oe", 16'(miso_oe), 16'd1);
    chk("t1_tx_ready_after_sel", 16'(bus.tx_ready), 16'd1);
    exp_q.push_back(8'h3C);
    xfer(8'h3C, 8, mi);
    chk("t1_miso_word", 16'(mi), 16'hA5);
    deselect;
    chk("t1_miso_oe_off", 16'(miso_oe), 16'd0);
    chk("t1_miso_off", 16'(miso), 16'd0);
    wait_drain;

    // Mode 3, LSB first
    set_mode(1'b1, 1'b1, 1'b1);
    load_tx(8'h81);
    select;
    exp_q.push_back(8'h0F);
    xfer(8'h0F, 8, mi);
    chk("t2_miso_word", 16'(mi), 16'h81);
    deselect;
    wait_drain;

    // Mode 1, two words in one select, holding reg empty for word 2
    set_mode(1'b0, 1'b1, 1'b0);
    load_tx(8'h5A);
    select;
    exp_q.push_back(8'h12);
    xfer(8'h12, 8, mi);
    chk("t3_miso_w1", 16'(mi), 16'h5A);
    exp_q.push_back(8'h34);
    xfer(8'h34, 8, mi);
    chk("t3_miso_w2", 16'(mi), 16'h00);
    deselect;
    wait_drain;

    // Mode 2, partial frame then full frame
    set_mode(1'b1, 1'b0, 1'b0);
    select;
    xfer(8'hFF, 5, mi);
    deselect;
    #200;
    chk("t4_partial_valid", 16'(bus.rx_valid), 16'd0);
    chk("t4_partial_data", 16'(bus.rx_data), 16'h34);
    select;
    exp_q.push_back(8'h55);
    xfer(8'h55, 8, mi);
    chk("t4_miso_empty", 16'(mi), 16'h00);
    deselect;
    wait_drain;

    // Two words without acknowledge
    set_mode(1'b0, 1'b0, 1'b0);
    mon_en = 1'b0;
    select;
    xfer(8'h11, 8, mi);
    xfer(8'h22, 8, mi);
    #HALF;
    chk("t5_valid_held", 16'(bus.rx_valid), 16'd1);
`ifdef SPI_SLAVE_RX_OVERRUN_EN
    chk("t5_data_kept", 16'(bus.rx_data), 16'h11);
    chk("t5_overrun_set", 16'(bus.rx_overrun), 16'd1);
    exp_q.push_back(8'h11);
`else
    chk("t5_data_overwritten", 16'(bus.rx_data), 16'h22);
    chk("t5_overrun_tied", 16'(bus.rx_overrun), 16'd0);
    exp_q.push_back(8'h22);
`endif
    deselect;
    chk("t5_overrun_clear", 16'(bus.rx_overrun), 16'd0);
    mon_en = 1'b1;
    wait_drain;

    // Asynchronous reset mid-frame
    load_tx(8'h99);
    select;
    xfer(8'hC3, 3, mi);
    #(HALF/2);
    reset = 1'b0;
    #1;
    chk("t6_miso", 16'(miso), 16'd0);
    chk("t6_miso_oe", 16'(miso_oe), 16'd0);
    chk("t6_tx_ready", 16'(bus.tx_ready), 16'd1);
    chk("t6_rx_valid", 16'(bus.rx_valid), 16'd0);
    chk("t6_rx_data", 16'(bus.rx_data), 16'd0);
    chk("t6_overrun", 16'(bus.rx_overrun), 16'd0);
    ss_n = 1'b1; sclk = cpol;
    #100 reset = 1'b1;
    #100;
    select;
    exp_q.push_back(8'hC3);
    xfer(8'hC3, 8, mi);
    chk("t6_miso_empty", 16'(mi), 16'h00);
    deselect;
    wait_drain;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
